// File: rtl/booth_r4_digit_serializer.sv
// Radix-4 Booth multiplier-digit serializer: loads an N-bit operand and streams
// one overlapping 3-bit Booth window per digit, with its decode, to the adder.
module booth_r4_digit_serializer #(
   parameter int unsigned N = 8,
   localparam int unsigned IW = $clog2(N / 2 + 2)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_valid,
   output logic          load_ready,
   input  logic [N-1:0]  din,
   input  logic          is_signed,
   output logic          dig_valid,
   input  logic          dig_ready,
   output logic [2:0]    window,
   output logic          dig_neg,
   output logic          dig_two,
   output logic          dig_zero,
   output logic [IW-1:0] dig_idx,
   output logic          dig_last
);

   localparam int unsigned SW    = N + 3;
   localparam int unsigned D_SGN = (N + 1) / 2;
   localparam int unsigned D_UNS = N / 2 + 1;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t          state;
   state_t          state_n;
   logic [SW-1:0]   sreg;
   logic            fill;
   logic [IW-1:0]   cnt;
   logic [IW-1:0]   idx;
   logic            ext;
   logic            dig_fire;
   logic            last_fire;
   logic            load_fire;

   // Extension bit: sign of the operand when signed, zero otherwise.
   assign ext = is_signed & din[N-1];

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Handshakes and next state; a load may coincide with last-digit acceptance.
   always_comb begin
      state_n    = state;
      dig_fire   = 1'b0;
      last_fire  = 1'b0;
      load_ready = 1'b0;
      load_fire  = 1'b0;
      case (state)
         IDLE: begin
            load_ready = 1'b1;
            load_fire  = load_valid;
            if (load_valid) state_n = SHIFT;
         end
         SHIFT: begin
            dig_fire   = dig_ready;
            last_fire  = dig_ready & dig_last;
            load_ready = last_fire;
            load_fire  = last_fire & load_valid;
            if (last_fire && !load_valid) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Operand shift register, extension fill, digit count and index.
   always_ff @(posedge clk) begin
      if (rst) begin
         sreg <= '0;
         fill <= 1'b0;
         cnt  <= '0;
         idx  <= '0;
      end else if (load_fire) begin
         sreg <= {{2{ext}}, din, 1'b0};
         fill <= ext;
         cnt  <= is_signed ? IW'(D_SGN) : IW'(D_UNS);
         idx  <= '0;
      end else if (dig_fire) begin
         sreg <= {fill, fill, sreg[SW-1:2]};
         idx  <= idx + IW'(1);
      end
   end

   assign dig_valid = (state == SHIFT);
   assign window    = sreg[2:0];
   assign dig_idx   = idx;
   assign dig_last  = (idx == cnt - IW'(1));

   // Booth decode of the current window.
   assign dig_neg  = window[2] & ~(window[1] & window[0]);
   assign dig_two  = (window == 3'b011) | (window == 3'b100);
   assign dig_zero = (window == 3'b000) | (window == 3'b111);

endmodule
